muldiv_seq: RTL and testbench

- Iterative RV32M multiply/divide unit. It sits beside the combinational ALU in the execute stage and covers the operations that ALU does not: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Selected by funct3 when funct7 = 0000001.
- Fixed-latency start/done handshake. The pipeline stalls on busy.
- Multiply is shift-add and divide is restoring shift-subtract. Both take one bit per cycle over 32 iterations.

---
 rtl/muldiv_pkg.sv | 51 +++++
 rtl/muldiv_seq_cond_neg32.sv | 24 ++
 rtl/muldiv_seq.sv | 203 ++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared constants, state encoding and funct3 decode helper
//                for the iterative RV32M multiply/divide unit.
//  Revision    : 1.0  initial release
// ============================================================================
package muldiv_pkg;

  // One result bit is produced per RUN cycle
  localparam int MD_ITERS = 32;

  // funct3 encodings when funct7 = 0000001
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  typedef struct packed {
    logic is_div;
    logic is_rem;
    logic is_signed_a;
    logic is_signed_b;
  } op_dec_t;

  // Classify an operation: divide vs multiply, remainder output, and which
  // operands are interpreted as two's complement.
  function automatic op_dec_t decode_op(input logic [2:0] op);
    op_dec_t d;
    d.is_div      = op[2];
    d.is_rem      = op[2] & op[1];
    d.is_signed_a = (op == OP_MULH) || (op == OP_MULHSU) ||
                    (op == OP_DIV)  || (op == OP_REM);
    d.is_signed_b = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_seq_cond_neg32.sv
`default_nettype none
// ============================================================================
//  Module      : cond_neg32
//  Description : Conditional two's-complement slice: y = (neg ? ~a : a) + cin.
//                With cin = neg it negates a 32-bit value; chaining cout into
//                the next slice's cin builds wider negators.
//  Revision    : 1.0  initial release
// ============================================================================
module cond_neg32 (
  input  logic [31:0] a,
  input  logic        neg,
  input  logic        cin,
  output logic [31:0] y,
  output logic        cout
);

  logic [31:0] w_inv;

  // Inverter stage followed by the incrementing adder
  assign w_inv     = a ^ {32{neg}};
  assign {cout, y} = {1'b0, w_inv} + {32'b0, cin};

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq
//  Description : Iterative RV32M multiply/divide unit. Shift-add multiply and
//                restoring divide on operand magnitudes, one bit per cycle,
//                with sign fix-up and RISC-V special-case results. Latency is
//                fixed: done pulses 35 cycles after the accepting edge.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = MD_ITERS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       operation,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(ITERS);

  state_t        r_state;
  state_t        w_next;

  logic [2:0]    r_op;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic [63:0]   r_acc;      // mul: {product hi, multiplier/product lo}; div: {rem, quo}
  logic [31:0]   r_opnd;     // mul: multiplicand magnitude; div: divisor magnitude
  logic          r_neg;      // sign to apply to the selected result
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_result;

  op_dec_t       w_dec;
  logic          w_sa;
  logic          w_sb;
  logic [31:0]   w_mag_a;
  logic [31:0]   w_mag_b;
  logic          w_unused_cout_a;
  logic          w_unused_cout_b;

  logic [32:0]   w_mul_sum;
  logic [63:0]   w_mul_next;
  logic [63:0]   w_div_sh;
  logic [32:0]   w_div_diff;
  logic          w_div_ok;
  logic [63:0]   w_div_next;

  logic [31:0]   w_fix_lo_in;
  logic [31:0]   w_fix_lo;
  logic [31:0]   w_fix_hi;
  logic          w_fix_carry;
  logic          w_unused_cout_hi;
  logic [31:0]   w_final;

  assign w_dec = decode_op(r_op);
  assign w_sa  = w_dec.is_signed_a & r_a[31];
  assign w_sb  = w_dec.is_signed_b & r_b[31];

  // Operand magnitudes; 0x80000000 maps to itself as an unsigned value
  cond_neg32 u_mag_a (
    .a    (r_a),
    .neg  (w_sa),
    .cin  (w_sa),
    .y    (w_mag_a),
    .cout (w_unused_cout_a)
  );

  cond_neg32 u_mag_b (
    .a    (r_b),
    .neg  (w_sb),
    .cin  (w_sb),
    .y    (w_mag_b),
    .cout (w_unused_cout_b)
  );

  // One multiply step and one restoring-divide step computed from the accumulator
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
    w_mul_next = {w_mul_sum, r_acc[31:1]};
    w_div_sh   = {r_acc[62:0], 1'b0};
    w_div_diff = {1'b0, w_div_sh[63:32]} + {1'b0, ~r_opnd} + 33'd1;
    // A bit shifted out of rem means the partial remainder exceeds any divisor
    w_div_ok   = w_div_diff[32] | r_acc[63];
    w_div_next = w_div_ok ? {w_div_diff[31:0], w_div_sh[31:1], 1'b1} : w_div_sh;
  end

  // For divides only the low slice output is used, fed with quotient or remainder
  assign w_fix_lo_in = (w_dec.is_div && w_dec.is_rem) ? r_acc[63:32] : r_acc[31:0];

  // 64-bit sign fix-up as two chained 32-bit slices
  cond_neg32 u_fix_lo (
    .a    (w_fix_lo_in),
    .neg  (r_neg),
    .cin  (r_neg),
    .y    (w_fix_lo),
    .cout (w_fix_carry)
  );

  cond_neg32 u_fix_hi (
    .a    (r_acc[63:32]),
    .neg  (r_neg),
    .cin  (w_fix_carry),
    .y    (w_fix_hi),
    .cout (w_unused_cout_hi)
  );

  // Output select with divide-by-zero and signed-overflow overrides
  always_comb begin
    w_final = w_fix_lo;
    if (w_dec.is_div) begin
      if (r_b == 32'd0) begin
        w_final = w_dec.is_rem ? r_a : 32'hFFFF_FFFF;
      end else if (w_dec.is_signed_b && (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF)) begin
        w_final = w_dec.is_rem ? 32'd0 : 32'h8000_0000;
      end
    end else if (r_op != OP_MUL) begin
      w_final = w_fix_hi;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and status outputs
  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = PREP;
      end
      PREP: w_next = RUN;
      RUN:  if (r_cnt == CW'(ITERS - 1)) w_next = FIX;
      FIX:  w_next = DONE;
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = IDLE;
      end
    endcase
  end

  // Datapath: latch, prepare magnitudes, iterate, write the result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op     <= 3'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_acc    <= 64'd0;
      r_opnd   <= 32'd0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_result <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op <= operation;
            r_a  <= a;
            r_b  <= b;
          end
        end
        PREP: begin
          r_opnd <= w_dec.is_div ? w_mag_b : w_mag_a;
          r_acc  <= {32'd0, (w_dec.is_div ? w_mag_a : w_mag_b)};
          r_neg  <= w_dec.is_rem ? w_sa : (w_sa ^ w_sb);
          r_cnt  <= '0;
        end
        RUN: begin
          r_acc <= w_dec.is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + CW'(1);
        end
        FIX: begin
          r_result <= w_final;
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_seq
//  Description : Directed self-checking bench for muldiv_seq.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  operation;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_pass  = 0;
  int n_total = 0;

  muldiv_seq #(.WIDTH(32), .ITERS(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .operation (operation),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Issue one op, scramble inputs after accept, wait (bounded) for done
  task automatic run_op(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                        output logic [31:0] res, output int lat, output int nbusy);
    @(negedge clk);
    start = 1'b1; operation = op; a = va; b = vb;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom; operation = 3'($urandom);
    lat = 0; nbusy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
    end while (!done && lat < 100);
    res = result;
  endtask

  task automatic do_vec(input string tag, input logic [2:0] op, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] exp);
    logic [31:0] res;
    int lat, nbusy;
    run_op(op, va, vb, res, lat, nbusy);
    check({tag, "_res"},  res, exp);
    check({tag, "_lat"},  32'(lat), 32'd35);
    check({tag, "_busy"}, 32'(nbusy), 32'd35);
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    check({tag, "_hold"}, result, exp);
  endtask

  initial begin
    logic [31:0] first_res;
    int          ndone;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; operation = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    rst_n = 1'b1;

    do_vec("mul",      OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    do_vec("mul_m1sq", OP_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001);
    do_vec("mulh",     OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
    do_vec("mulhu",    OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_vec("mulhu_x2", OP_MULHU,  32'hFFFF_FFFF,  32'd2,         32'h0000_0001);
    do_vec("mulhsu",   OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_vec("div",      OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
    do_vec("rem",      OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
    do_vec("div_nd",   OP_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD);
    do_vec("rem_nd",   OP_REM,    32'd7,          32'hFFFF_FFFE, 32'h0000_0001);
    do_vec("divu",     OP_DIVU,   32'd100,        32'd7,         32'd14);
    do_vec("remu",     OP_REMU,   32'd100,        32'd7,         32'd2);
    do_vec("divu_big", OP_DIVU,   32'hFFFF_FFFF,  32'h8000_0001, 32'h0000_0001);
    do_vec("remu_big", OP_REMU,   32'hFFFF_FFFF,  32'h8000_0001, 32'h7FFF_FFFE);
    do_vec("divu_z",   OP_DIVU,   32'h1234_5678,  32'd0,         32'hFFFF_FFFF);
    do_vec("remu_z",   OP_REMU,   32'h1234_5678,  32'd0,         32'h1234_5678);
    do_vec("div_z",    OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF);
    do_vec("rem_z",    OP_REM,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB);
    do_vec("div_ovf",  OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
    do_vec("rem_ovf",  OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000);

    // Second start while busy must be ignored, not queued
    @(negedge clk);
    start = 1'b1; operation = OP_DIVU; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0; first_res = '0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 10) begin start = 1'b1; operation = OP_MUL; a = 32'd3; b = 32'd5; end
      if (k == 11) start = 1'b0;
      if (done) begin
        if (ndone == 0) first_res = result;
        ndone++;
      end
    end
    check("busy_start_ndone", 32'(ndone), 32'd1);
    check("busy_start_res", first_res, 32'd14);
    check("busy_start_hold", result, 32'd14);

    // Reset in the middle of RUN abandons the op
    @(negedge clk);
    start = 1'b1; operation = OP_MUL; a = 32'd6; b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (17) @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    rst_n = 1'b1;
    ndone = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("mid_rst_nodone", 32'(ndone), 32'd0);
    do_vec("after_rst", OP_MUL, 32'd6, 32'd7, 32'd42);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
